perceptron_trainer: RTL and testbench

Parametrised on-chip perceptron training engine: stores a small labelled sample set, then runs epochs of serial multiply-accumulate, threshold activation and error-driven weight/bias updates until an epoch finishes error-free or an epoch limit is reached. It generalises the fixed 2-input, 3-sample perceptron datapath to N_DIM inputs, N_SAMPLES samples and DATA_W-bit signed data. It adds a load handshake, a training FSM, convergence detection and a weight readout. It sits behind the top-level pin wrapper, which maps its ports onto ui/uo/uio.

---
 rtl/perceptron_pkg.sv | 49 ++++
 rtl/perceptron_mac.sv | 35 +++
 rtl/perceptron_trainer.sv | 204 ++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron training engine.
// PERCEPTRON_SAT_EN: weight/bias updates saturate instead of wrapping.
package perceptron_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_UPD  = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef PERCEPTRON_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int unsigned ARITH_W = 32;

  // Index width for an array of n entries (never zero).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // a + b, clipped to a signed w-bit range when saturation is enabled; the caller truncates to w bits.
  function automatic logic signed [ARITH_W-1:0] upd_add(input logic signed [ARITH_W-1:0] a,
                                                         input logic signed [ARITH_W-1:0] b,
                                                         input int unsigned               w);
    logic signed [ARITH_W-1:0] s;
    logic signed [ARITH_W-1:0] hi;
    logic signed [ARITH_W-1:0] lo;
    s  = a + b;
    hi = (ARITH_W'(1) <<< (w - 1)) - ARITH_W'(1);
    lo = ~hi;
    if (SAT_EN && (s > hi)) begin
      s = hi;
    end else if (SAT_EN && (s < lo)) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Serial signed multiply-accumulate; i_clr preloads the sign-extended bias in the same step.
module perceptron_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_step,
  input  logic signed [DATA_W-1:0] i_bias,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_base;
  logic signed [ACC_W-1:0]    w_add;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_x * i_w;
  assign w_base = i_clr ? ACC_W'(i_bias) : r_acc;
  assign w_add  = i_step ? ACC_W'(w_prod) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr || i_step) begin
      r_acc <= w_base + w_add;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training engine: sample memory, training FSM, weight/bias registers.
// PERCEPTRON_SAT_EN selects saturating (defined) or wrapping (undefined) updates.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int unsigned N_DIM      = 2,
  parameter int unsigned N_SAMPLES  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_EPOCHS = 15,
  parameter int unsigned LR_SHIFT   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [N_DIM*DATA_W-1:0]         ld_x,
  input  logic                            ld_y,
  input  logic                            start,
  input  logic                            clr,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [cnt_w(MAX_EPOCHS)-1:0]    epoch_cnt,
  output logic [cnt_w(N_SAMPLES)-1:0]     err_cnt,
  output logic [N_DIM*DATA_W-1:0]         w_out,
  output logic [DATA_W-1:0]               b_out
);

  localparam int unsigned EP_W  = cnt_w(MAX_EPOCHS);
  localparam int unsigned ERR_W = cnt_w(N_SAMPLES);
  localparam int unsigned PTR_W = cnt_w(N_SAMPLES);
  localparam int unsigned SMP_W = idx_w(N_SAMPLES);
  localparam int unsigned DIM_W = idx_w(N_DIM);
  localparam int unsigned ACC_W = 2*DATA_W + $clog2(N_DIM) + 1;

  state_t r_state, w_state_nxt;

  logic signed [DATA_W-1:0] r_mem_x [N_SAMPLES][N_DIM];
  logic                     r_mem_y [N_SAMPLES];
  logic signed [DATA_W-1:0] r_w [N_DIM];
  logic signed [DATA_W-1:0] r_b;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [SMP_W-1:0]         r_smp_idx;
  logic [DIM_W-1:0]         r_dim_idx;
  logic [EP_W-1:0]          r_epoch;
  logic [ERR_W-1:0]         r_err;
  logic                     r_conv, r_done, r_busy, r_ld_ready;

  logic                     w_load, w_clear, w_start, w_mac_first, w_mac_step, w_upd, w_chk;
  logic                     w_last_dim, w_last_smp, w_stop, w_y, w_yhat, w_err;
  logic [PTR_W-1:0]         w_wr_ptr_nxt;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_delta [N_DIM];
  logic signed [DATA_W-1:0] w_w_upd [N_DIM];
  logic signed [DATA_W-1:0] w_b_upd;

  assign w_last_dim = (r_dim_idx == DIM_W'(N_DIM - 1));
  assign w_last_smp = (PTR_W'(r_smp_idx) == (r_wr_ptr - PTR_W'(1)));
  assign w_stop     = (r_err == '0) || (r_epoch == EP_W'(MAX_EPOCHS - 1));
  assign w_y        = r_mem_y[r_smp_idx];
  assign w_yhat     = !w_acc[ACC_W-1] && (w_acc != '0);
  assign w_err      = w_y ^ w_yhat;

  perceptron_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_mac_first),
    .i_step (w_mac_step),
    .i_bias (r_b),
    .i_x    (r_mem_x[r_smp_idx][r_dim_idx]),
    .i_w    (r_w[r_dim_idx]),
    .o_acc  (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = ld_valid && r_ld_ready;
    w_clear     = 1'b0;
    w_start     = 1'b0;
    w_mac_first = 1'b0;
    w_mac_step  = 1'b0;
    w_upd       = 1'b0;
    w_chk       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (clr) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (start && ((r_wr_ptr != '0) || w_load)) begin
          w_start     = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_mac_step  = 1'b1;
        w_mac_first = (r_dim_idx == '0);
        if (w_last_dim) w_state_nxt = S_UPD;
      end
      S_UPD: begin
        w_upd       = 1'b1;
        w_state_nxt = w_last_smp ? S_CHK : S_MAC;
      end
      S_CHK: begin
        w_chk       = 1'b1;
        w_state_nxt = w_stop ? S_DONE : S_MAC;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_wr_ptr_nxt = w_clear ? '0 : (w_load ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr);
  end

  // Error-driven update candidates: e = +1 when label is 1, -1 when label is 0.
  always_comb begin
    for (int unsigned i = 0; i < N_DIM; i++) begin
      w_delta[i] = r_mem_x[r_smp_idx][i] >>> LR_SHIFT;
      w_w_upd[i] = DATA_W'(upd_add(ARITH_W'(r_w[i]),
                                   w_y ? ARITH_W'(w_delta[i]) : -ARITH_W'(w_delta[i]), DATA_W));
    end
    w_b_upd = DATA_W'(upd_add(ARITH_W'(r_b), w_y ? 32'sd1 : -32'sd1, DATA_W));
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int unsigned i = 0; i < N_DIM; i++) begin
        r_mem_x[SMP_W'(r_wr_ptr)][i] <= ld_x[i*DATA_W +: DATA_W];
      end
      r_mem_y[SMP_W'(r_wr_ptr)] <= ld_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_DIM; i++) r_w[i] <= '0;
      r_b        <= '0;
      r_wr_ptr   <= '0;
      r_smp_idx  <= '0;
      r_dim_idx  <= '0;
      r_epoch    <= '0;
      r_err      <= '0;
      r_conv     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ld_ready <= 1'b1;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_ld_ready <= (w_state_nxt == S_IDLE) && (w_wr_ptr_nxt < PTR_W'(N_SAMPLES));
      r_done     <= (w_state_nxt == S_DONE);
      r_busy     <= (w_state_nxt == S_MAC) || (w_state_nxt == S_UPD) || (w_state_nxt == S_CHK);
      if (w_clear) begin
        for (int unsigned i = 0; i < N_DIM; i++) r_w[i] <= '0;
        r_b    <= '0;
        r_conv <= 1'b0;
      end
      if (w_start) begin
        r_smp_idx <= '0;
        r_dim_idx <= '0;
        r_epoch   <= '0;
        r_err     <= '0;
        r_conv    <= 1'b0;
      end
      if (w_mac_step) begin
        r_dim_idx <= w_last_dim ? '0 : (r_dim_idx + DIM_W'(1));
      end
      if (w_upd) begin
        r_smp_idx <= w_last_smp ? '0 : (r_smp_idx + SMP_W'(1));
        if (w_err) begin
          for (int unsigned i = 0; i < N_DIM; i++) r_w[i] <= w_w_upd[i];
          r_b   <= w_b_upd;
          r_err <= r_err + ERR_W'(1);
        end
      end
      if (w_chk) begin
        r_epoch <= r_epoch + EP_W'(1);
        if (r_err == '0) r_conv <= 1'b1;
        if (!w_stop) r_err <= '0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_DIM; i++) w_out[i*DATA_W +: DATA_W] = r_w[i];
  end

  assign b_out     = r_b;
  assign ld_ready  = r_ld_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign converged = r_conv;
  assign epoch_cnt = r_epoch;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer with a behavioural training model and result scoreboard.
module tb_perceptron_trainer;

  localparam int N_DIM = 2, N_SAMPLES = 4, DATA_W = 8, MAX_EPOCHS = 15, LR_SHIFT = 0;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ld_valid = 1'b0, ld_y = 1'b0, start = 1'b0, clr = 1'b0;
  logic [15:0] ld_x = '0;
  logic        ld_ready, busy, done, converged;
  logic [3:0]  epoch_cnt;
  logic [2:0]  err_cnt;
  logic [15:0] w_out;
  logic [7:0]  b_out;

  perceptron_trainer #(
    .N_DIM(N_DIM), .N_SAMPLES(N_SAMPLES), .DATA_W(DATA_W), .MAX_EPOCHS(MAX_EPOCHS), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .clr(clr), .busy(busy), .done(done), .converged(converged),
    .epoch_cnt(epoch_cnt), .err_cnt(err_cnt), .w_out(w_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  typedef struct {int w0; int w1; int b; int ep; int err; int conv; int cyc;} exp_t;
  exp_t sb_q[$];

  int n_tests = 0, n_fail = 0;
  int mx[N_SAMPLES][N_DIM];
  int my[N_SAMPLES];
  int mw[N_DIM];
  int mn = 0, mb = 0;
  int last_cyc = 0;

  function automatic int fix8(input int v);
`ifdef PERCEPTRON_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    byte t;
    t = byte'(v);
    return int'(t);
`endif
  endfunction

  function automatic exp_t model_train();
    exp_t r;
    int ep, errs, acc, e;
    ep = 0;
    do begin
      errs = 0;
      for (int s = 0; s < mn; s++) begin
        acc = mb;
        for (int d = 0; d < N_DIM; d++) acc += mx[s][d] * mw[d];
        e = my[s] - ((acc > 0) ? 1 : 0);
        if (e != 0) begin
          for (int d = 0; d < N_DIM; d++) mw[d] = fix8(mw[d] + e * (mx[s][d] >>> LR_SHIFT));
          mb = fix8(mb + e);
          errs++;
        end
      end
      ep++;
    end while (errs != 0 && ep < MAX_EPOCHS);
    r.w0 = mw[0]; r.w1 = mw[1]; r.b = mb; r.ep = ep; r.err = errs;
    r.conv = (errs == 0) ? 1 : 0;
    r.cyc = ep * (mn * (N_DIM + 1) + 1) + 1;
    return r;
  endfunction

  task automatic model_clear();
    mn = 0; mb = 0;
    for (int d = 0; d < N_DIM; d++) mw[d] = 0;
  endtask

  task automatic load_sample(input int x0, input int x1, input int y);
    int exp_rdy;
    exp_rdy = (mn < N_SAMPLES) ? 1 : 0;
    n_tests++;
    if (ld_ready !== 1'(exp_rdy)) begin
      n_fail++;
      $display("FAIL ld_ready slot %0d: got %b want %0d", mn, ld_ready, exp_rdy);
    end
    ld_valid = 1'b1; ld_x = {8'(x1), 8'(x0)}; ld_y = 1'(y);
    @(negedge clk);
    ld_valid = 1'b0;
    if (exp_rdy != 0) begin
      mx[mn][0] = x0; mx[mn][1] = x1; my[mn] = y; mn++;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  // Caller raises start at a negedge; expected result is pushed, then compared when done rises.
  task automatic run_training(input int disturb, input int snap_cyc, input int snap_w0);
    exp_t e;
    int cyc, g0, g1, gb;
    sb_q.push_back(model_train());
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      if (cyc == snap_cyc) begin
        g0 = $signed(w_out[7:0]);
        n_tests++;
        if (g0 !== snap_w0) begin n_fail++; $display("FAIL snapshot w0 @%0d: got %0d want %0d", cyc, g0, snap_w0); end
      end
      if (disturb != 0) begin
        if (cyc == 20) start = 1'b1;
        if (cyc == 21) begin start = 1'b0; clr = 1'b1; end
        if (cyc == 22) clr = 1'b0;
        if (cyc == 25) begin
          n_tests++;
          if (busy !== 1'b1) begin n_fail++; $display("FAIL busy after mid pulses: got %b want 1", busy); end
        end
      end
      @(negedge clk);
      cyc++;
    end
    last_cyc = cyc;
    e = sb_q.pop_front();
    g0 = $signed(w_out[7:0]); g1 = $signed(w_out[15:8]); gb = $signed(b_out);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL done timeout: got %b want 1", done); end
    n_tests++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL done latency: got %0d want %0d", cyc, e.cyc); end
    n_tests++; if (g0 !== e.w0) begin n_fail++; $display("FAIL w0: got %0d want %0d", g0, e.w0); end
    n_tests++; if (g1 !== e.w1) begin n_fail++; $display("FAIL w1: got %0d want %0d", g1, e.w1); end
    n_tests++; if (gb !== e.b) begin n_fail++; $display("FAIL bias: got %0d want %0d", gb, e.b); end
    n_tests++; if (int'(epoch_cnt) !== e.ep) begin n_fail++; $display("FAIL epoch_cnt: got %0d want %0d", epoch_cnt, e.ep); end
    n_tests++; if (int'(err_cnt) !== e.err) begin n_fail++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, e.err); end
    n_tests++; if (int'(converged) !== e.conv) begin n_fail++; $display("FAIL converged: got %b want %0d", converged, e.conv); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy at done: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_tests++; if (converged !== 1'b0) begin n_fail++; $display("FAIL reset converged: got %b want 0", converged); end
    n_tests++; if (epoch_cnt !== 4'd0) begin n_fail++; $display("FAIL reset epoch_cnt: got %0d want 0", epoch_cnt); end
    n_tests++; if (err_cnt !== 3'd0) begin n_fail++; $display("FAIL reset err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (w_out !== 16'h0000) begin n_fail++; $display("FAIL reset w_out: got %h want 0000", w_out); end
    n_tests++; if (b_out !== 8'h00) begin n_fail++; $display("FAIL reset b_out: got %h want 00", b_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset ld_ready: got %b want 1", ld_ready); end
    model_clear();
  endtask

  task automatic test_and();
    load_sample(0, 0, 0); load_sample(0, 1, 0); load_sample(1, 0, 0); load_sample(1, 1, 1);
    start = 1'b1;
    run_training(0, 0, 0);
    n_tests++; if (w_out !== 16'h0102) begin n_fail++; $display("FAIL and w_out: got %h want 0102", w_out); end
    n_tests++; if (b_out !== 8'hFE) begin n_fail++; $display("FAIL and b_out: got %h want fe", b_out); end
    n_tests++; if (epoch_cnt !== 4'd6) begin n_fail++; $display("FAIL and epochs: got %0d want 6", epoch_cnt); end
    n_tests++; if (last_cyc !== 79) begin n_fail++; $display("FAIL and latency: got %0d want 79", last_cyc); end
  endtask

  task automatic test_restart();
    start = 1'b1;
    run_training(0, 0, 0);
    n_tests++; if (epoch_cnt !== 4'd1) begin n_fail++; $display("FAIL restart epochs: got %0d want 1", epoch_cnt); end
  endtask

  task automatic test_clr_done();
    pulse_clr();
    n_tests++; if (w_out !== 16'h0000) begin n_fail++; $display("FAIL clr w_out: got %h want 0000", w_out); end
    n_tests++; if (b_out !== 8'h00) begin n_fail++; $display("FAIL clr b_out: got %h want 00", b_out); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL clr done: got %b want 0", done); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL clr ld_ready: got %b want 1", ld_ready); end
  endtask

  task automatic test_xor_control();
    load_sample(0, 0, 0); load_sample(0, 1, 1); load_sample(1, 0, 1); load_sample(1, 1, 0);
    start = 1'b1;
    run_training(1, 0, 0);
    n_tests++; if (converged !== 1'b0) begin n_fail++; $display("FAIL xor converged: got %b want 0", converged); end
    n_tests++; if (epoch_cnt !== 4'd15) begin n_fail++; $display("FAIL xor epochs: got %0d want 15", epoch_cnt); end
    n_tests++; if (err_cnt === 3'd0) begin n_fail++; $display("FAIL xor err_cnt: got 0 want nonzero"); end
  endtask

  task automatic test_saturation();
    pulse_clr();
    load_sample(100, -100, 1); load_sample(100, 110, 1);
    start = 1'b1;
    run_training(0, 7, fix8(fix8(100) + 100));
  endtask

  task automatic test_load_bounds();
    pulse_clr();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty start busy: got %b want 0", busy); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL empty start ld_ready: got %b want 1", ld_ready); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load+start ready: got %b want 1", ld_ready); end
    ld_valid = 1'b1; ld_x = {8'sd1, 8'sd1}; ld_y = 1'b1; start = 1'b1;
    mx[0][0] = 1; mx[0][1] = 1; my[0] = 1; mn = 1;
    run_training(0, 0, 0);
    pulse_clr();
    for (int k = 0; k < 5; k++) load_sample(k, -k, k & 1);
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full ld_ready: got %b want 0", ld_ready); end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    load_sample(0, 0, 0); load_sample(0, 1, 0); load_sample(1, 0, 0); load_sample(1, 1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre-reset busy: got %b want 1", busy); end
    n_tests++; if (epoch_cnt !== 4'd1) begin n_fail++; $display("FAIL pre-reset epoch: got %0d want 1", epoch_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL async done: got %b want 0", done); end
    n_tests++; if (epoch_cnt !== 4'd0) begin n_fail++; $display("FAIL async epoch: got %0d want 0", epoch_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset ld_ready: got %b want 1", ld_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post-reset busy: got %b want 0", busy); end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_and();
    test_restart();
    test_clr_done();
    test_xor_control();
    test_saturation();
    test_load_bounds();
    test_reset_mid();
    n_tests++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
